cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source {tag,data} queues, round-robin grant, one broadcast per cycle.
// Latency: an entry accepted into an empty queue is broadcast one edge later, from registered outputs.
// Backpressure: src_ready[i] drops while queue i is full; CDB_ARB_STATS_EN adds bcast_cnt/stall_cnt.

module cdb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

module cdb_arbiter #(
    parameter int NUM_SRC = 7,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int QDEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic [$clog2(NUM_SRC)-1:0]  cdb_src
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [15:0]                 bcast_cnt,
    output logic [15:0]                 stall_cnt
`endif
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             head  [NUM_SRC];
    logic [CW-1:0]      count [NUM_SRC];
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] nonempty;

    logic               gnt_vld;
    logic [SW-1:0]      gnt_idx;
    logic [SW-1:0]      rr_ptr;
    logic [SW-1:0]      rr_nxt;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            // Ready looks only at the registered count, so a same-edge pop never reopens a full queue.
            assign src_ready[g] = (count[g] != CW'(QDEPTH));
            assign nonempty[g]  = (count[g] != '0);
            assign push[g]      = src_valid[g] & src_ready[g];
            assign pop[g]       = gnt_vld && (gnt_idx == SW'(g));

            cdb_fifo #(
                .W     ($bits(entry_t)),
                .DEPTH (QDEPTH)
            ) u_q (
                .clk      (clk),
                .reset    (reset),
                .push     (push[g]),
                .push_dat ({src_tag[g*TAG_W +: TAG_W], src_data[g*DATA_W +: DATA_W]}),
                .pop      (pop[g]),
                .head_dat (head[g]),
                .count    (count[g])
            );
        end
    endgenerate

    // First non-empty queue at or after rr_ptr, wrapping past the last source.
    always_comb begin
        int            idx;
        logic [SW-1:0] idx_s;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        idx_s   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            idx_s = SW'(idx);
            if (!gnt_vld && nonempty[idx_s]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_s;
            end
        end
    end

    assign rr_nxt = (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + SW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= gnt_vld;
            if (gnt_vld) begin
                cdb_tag  <= head[gnt_idx].tag;
                cdb_data <= head[gnt_idx].data;
                cdb_src  <= gnt_idx;
                rr_ptr   <= rr_nxt;
            end else begin
                cdb_tag  <= '0;
                cdb_data <= '0;
                cdb_src  <= '0;
            end
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic any_stall;
    assign any_stall = |(src_valid & ~src_ready);

    // bcast_cnt steps on the edge that loads a broadcast, so it already includes the cycle now on the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcast_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (gnt_vld && bcast_cnt != 16'hFFFF) begin
                bcast_cnt <= bcast_cnt + 16'd1;
            end
            if (any_stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
